// File: rtl/mat_result_packer_if.sv
// -----------------------------------------------------------------------------
// mat_result_packer_if
// Bundles the element stream, the word-memory write port and the control and
// status lines of the result packer.
//   slave  modport : the packer itself
//   master modport : whoever feeds elements, grants writes and issues start
// Signals:
//   start      pulse that begins a matrix transfer (honoured only when idle)
//   base_addr  word address of C[0][0]
//   elem_valid / elem_data / elem_ready   byte stream, row-major
//   wr_en / wr_addr / wr_data / wr_be / wr_gnt   word write request and grant
//   busy       transfer in progress
//   done       single-cycle completion pulse
// -----------------------------------------------------------------------------
interface mat_result_packer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              elem_valid;
  logic [7:0]        elem_data;
  logic              elem_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic              wr_gnt;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, elem_valid, elem_data, wr_gnt,
    output elem_ready, wr_en, wr_addr, wr_data, wr_be, busy, done
  );

  modport master (
    output start, base_addr, elem_valid, elem_data, wr_gnt,
    input  elem_ready, wr_en, wr_addr, wr_data, wr_be, busy, done
  );
endinterface

// File: rtl/mat_result_packer.sv
// -----------------------------------------------------------------------------
// mat_result_packer
// Packs a row-major stream of 8-bit result elements of an N x N matrix into
// 32-bit words, four lanes per word with lane 0 in bits [7:0]. Each row starts
// on a fresh word, so element (r,c) lands in word base + r*ceil(N/4) + c/4,
// lane c%4. The last word of a row is partial when N is not a multiple of 4;
// its unfilled lanes read as 0x00 and are excluded from the byte enables.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      mat_result_packer_if.slave (stream in, word writes out, status)
// -----------------------------------------------------------------------------
module mat_result_packer #(
  parameter int MAT_SIZE = 2,   // N, legal range 1..64
  parameter int ADDR_W   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mat_result_packer_if.slave  bus
);

  // Counters are 7 bits so N = 64 fits with room for the compare constant.
  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAT_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_row;
  logic [CNT_W-1:0]  r_col;
  logic [3:0][7:0]   r_buf;
  logic [3:0]        r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last;     // buffered word holds C[N-1][N-1]

  logic              w_accept;
  logic              w_grant;
  logic [1:0]        w_lane;
  logic              w_col_end;
  logic              w_row_end;
  logic              w_in_write;
  logic [31:0]       w_wr_data;

  assign w_lane     = r_col[1:0];
  assign w_col_end  = (r_col == LAST_IDX);
  assign w_row_end  = (r_row == LAST_IDX);
  assign w_in_write = (r_state == S_WRITE);
  assign w_accept   = (r_state == S_COLLECT) && bus.elem_valid;
  assign w_grant    = w_in_write && bus.wr_gnt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A word is flushed when its top lane fills or the row ends.
        if (w_accept && ((w_lane == 2'd3) || w_col_end)) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.wr_gnt) begin
          w_state_next = r_last ? S_DONE : S_COLLECT;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, lane buffer, address
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row  <= '0;
      r_col  <= '0;
      r_buf  <= '0;
      r_mask <= '0;
      r_addr <= '0;
      r_last <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_addr <= bus.base_addr;
            r_row  <= '0;
            r_col  <= '0;
            r_buf  <= '0;
            r_mask <= '0;
            r_last <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_buf[w_lane]  <= bus.elem_data;
            r_mask[w_lane] <= 1'b1;
            r_last         <= w_row_end && w_col_end;
            if (w_col_end) begin
              r_col <= '0;
              r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (w_grant) begin
            // Address wraps silently modulo 2^ADDR_W.
            r_addr <= r_addr + 1'b1;
            r_buf  <= '0;
            r_mask <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write port: lanes outside the mask are forced to zero, and the whole port
  // reads as zero whenever no write is being requested.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wr_data[gi*8 +: 8] = (w_in_write && r_mask[gi]) ? r_buf[gi] : 8'h00;
    end
  endgenerate

  assign bus.elem_ready = (r_state == S_COLLECT);
  assign bus.wr_en      = w_in_write;
  assign bus.wr_addr    = w_in_write ? r_addr : '0;
  assign bus.wr_data    = w_wr_data;
  assign bus.wr_be      = w_in_write ? r_mask : 4'h0;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);

endmodule

// File: tb/tb_mat_result_packer.sv
// -----------------------------------------------------------------------------
// tb_mat_result_packer
// Three packer instances (N = 2, 4, 5) on one clock and reset, driven by
// directed transfers. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mat_result_packer;

  typedef struct packed {
    logic [1:0]  d;
    logic [7:0]  a;
    logic [31:0] w;
    logic [3:0]  be;
  } wr_t;

  logic clk;
  logic rst_n;

  // Per-instance stimulus (driven from the main initial block)
  logic       st     [3];
  logic [7:0] ba     [3];
  logic       vld    [3];
  logic [7:0] dat    [3];
  int         stall  [3];
  logic       spam   [3];
  // Per-instance stimulus driven by the grant/start helper process
  logic       gnt    [3];
  logic       spam_st[3];
  int         scnt   [3];
  // Per-instance observed outputs
  logic       rdy    [3];
  logic       wen    [3];
  logic       bsy    [3];
  logic       dn     [3];
  logic [7:0] wa     [3];
  logic [31:0] wd    [3];
  logic [3:0] wb     [3];

  // Monitor state
  wr_t        wq[$];
  int         last_gcyc [3];
  int         stall_seen[3];
  logic       prev_stall[3];
  logic [7:0] pa [3];
  logic [31:0] pd[3];
  logic [3:0] pb [3];
  int         stab_bad;
  int         cyc;

  int n_checks;
  int n_pass;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      mat_result_packer_if #(.ADDR_W(8)) bus ();
      mat_result_packer #(
        .MAT_SIZE ((gi == 0) ? 2 : (gi == 1) ? 4 : 5),
        .ADDR_W   (8)
      ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
      );
      assign bus.start      = st[gi] | spam_st[gi];
      assign bus.base_addr  = ba[gi];
      assign bus.elem_valid = vld[gi];
      assign bus.elem_data  = dat[gi];
      assign bus.wr_gnt     = gnt[gi];
      assign rdy[gi] = bus.elem_ready;
      assign wen[gi] = bus.wr_en;
      assign bsy[gi] = bus.busy;
      assign dn[gi]  = bus.done;
      assign wa[gi]  = bus.wr_addr;
      assign wd[gi]  = bus.wr_data;
      assign wb[gi]  = bus.wr_be;
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Grant and spurious-start generation: wr_gnt is held low for stall[d]
  // cycles of every write; spam[d] asserts start in every busy cycle.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      if (!wen[d]) begin
        scnt[d] = 0;
        gnt[d]  = (stall[d] == 0);
      end else if (scnt[d] < stall[d]) begin
        scnt[d] = scnt[d] + 1;
        gnt[d]  = 1'b0;
      end else begin
        gnt[d]  = 1'b1;
      end
      spam_st[d] = spam[d] && bsy[d];
    end
  end

  // Write monitor: logs granted writes and audits stalled writes.
  initial stab_bad = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (wen[d] && gnt[d]) begin
          wq.push_back('{d: 2'(d), a: wa[d], w: wd[d], be: wb[d]});
          last_gcyc[d] = cyc;
        end
        if (wen[d] && !gnt[d]) begin
          stall_seen[d] = stall_seen[d] + 1;
          if (rdy[d]) stab_bad = stab_bad + 1;
        end
        if (wen[d] && prev_stall[d] &&
            ((wa[d] != pa[d]) || (wd[d] != pd[d]) || (wb[d] != pb[d]))) begin
          stab_bad = stab_bad + 1;
        end
        prev_stall[d] = wen[d] && !gnt[d];
        pa[d] = wa[d];
        pd[d] = wd[d];
        pb[d] = wb[d];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
      $display("check %s: 0x%08h ok", tag, got);
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet_outputs(input int d, input string tag);
    chk($sformatf("%s_ready%0d", tag, d), 32'(rdy[d]), 32'h0);
    chk($sformatf("%s_wren%0d",  tag, d), 32'(wen[d]), 32'h0);
    chk($sformatf("%s_busy%0d",  tag, d), 32'(bsy[d]), 32'h0);
    chk($sformatf("%s_done%0d",  tag, d), 32'(dn[d]),  32'h0);
    chk($sformatf("%s_addr%0d",  tag, d), 32'(wa[d]),  32'h0);
    chk($sformatf("%s_data%0d",  tag, d), wd[d],       32'h0);
    chk($sformatf("%s_be%0d",    tag, d), 32'(wb[d]),  32'h0);
  endtask

  // All tasks below start and end 1 ns after a rising edge.
  task automatic start_xfer(input int d, input logic [7:0] base);
    st[d] = 1'b1;
    ba[d] = base;
    @(posedge clk);
    #1;
    st[d] = 1'b0;
  endtask

  task automatic feed(input int d, input logic [7:0] first, input int count);
    for (int i = 0; i < count; i++) begin
      int w;
      w = 0;
      vld[d] = 1'b1;
      dat[d] = 8'(first + i);
      @(negedge clk);
      while (!rdy[d] && w < 100) begin
        @(negedge clk);
        w = w + 1;
      end
      if (!rdy[d]) begin
        chk("feed_timeout", 32'h0, 32'h1);
        vld[d] = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    vld[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int w;
    w = 0;
    @(negedge clk);
    while (!dn[d] && w < 200) begin
      @(negedge clk);
      w = w + 1;
    end
    chk("done_seen", 32'(dn[d]), 32'h1);
    if (dn[d]) chk("done_latency", 32'(cyc - last_gcyc[d]), 32'h1);
    @(negedge clk);
    chk("busy_after_done", 32'(bsy[d]), 32'h0);
    chk("done_one_cycle", 32'(dn[d]), 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Expected word list from the placement rule:
  // element (r,c) = first + r*n + c goes to word base + r*wpr + c/4, lane c%4.
  task automatic check_writes(input int d, input logic [7:0] base, input logic [7:0] first,
                              input int n, input int idx0);
    int wpr;
    int k;
    int c;
    logic [31:0] ed;
    logic [3:0]  eb;
    logic [7:0]  ea;
    wpr = (n + 3) / 4;
    k = idx0;
    chk($sformatf("wr_count%0d", d), 32'(wq.size() - idx0), 32'(n * wpr));
    for (int r = 0; r < n; r++) begin
      for (int wi = 0; wi < wpr; wi++) begin
        ed = 32'h0;
        eb = 4'h0;
        for (int l = 0; l < 4; l++) begin
          c = wi * 4 + l;
          if (c < n) begin
            ed[l*8 +: 8] = 8'(first + r * n + c);
            eb[l] = 1'b1;
          end
        end
        ea = 8'(base + r * wpr + wi);
        if (k < wq.size()) begin
          chk($sformatf("wr%0d_addr_r%0d_w%0d", d, r, wi), 32'(wq[k].a),  32'(ea));
          chk($sformatf("wr%0d_data_r%0d_w%0d", d, r, wi), wq[k].w,       ed);
          chk($sformatf("wr%0d_be_r%0d_w%0d",   d, r, wi), 32'(wq[k].be), 32'(eb));
        end
        k = k + 1;
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; ba[d] = 8'h00; vld[d] = 1'b0; dat[d] = 8'h00;
      stall[d] = 0; spam[d] = 1'b0;
      stall_seen[d] = 0; last_gcyc[d] = 0; prev_stall[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk_quiet_outputs(d, "reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // N=2, base 0x10, grant always high
    idx = wq.size();
    start_xfer(0, 8'h10);
    feed(0, 8'h01, 4);
    wait_done(0);
    chk("n2_count", 32'(wq.size() - idx), 32'd2);
    if (wq.size() >= idx + 2) begin
      chk("n2_w0_addr", 32'(wq[idx].a),    32'h10);
      chk("n2_w0_data", wq[idx].w,         32'h00000201);
      chk("n2_w0_be",   32'(wq[idx].be),   32'h3);
      chk("n2_w1_addr", 32'(wq[idx+1].a),  32'h11);
      chk("n2_w1_data", wq[idx+1].w,       32'h00000403);
      chk("n2_w1_be",   32'(wq[idx+1].be), 32'h3);
    end

    // N=4, base 0, three stall cycles per write
    stall[1] = 3;
    idx = wq.size();
    start_xfer(1, 8'h00);
    feed(1, 8'h00, 16);
    wait_done(1);
    check_writes(1, 8'h00, 8'h00, 4, idx);
    if (wq.size() >= idx + 4) chk("n4_w3_data", wq[idx+3].w, 32'h0F0E0D0C);
    chk("n4_stall_cycles", 32'(stall_seen[1]), 32'd12);
    chk("n4_stall_stable", 32'(stab_bad), 32'd0);
    stall[1] = 0;

    // N=5, base 0x20: partial last word per row
    idx = wq.size();
    start_xfer(2, 8'h20);
    feed(2, 8'h01, 25);
    wait_done(2);
    check_writes(2, 8'h20, 8'h01, 5, idx);
    if (wq.size() >= idx + 10) begin
      chk("n5_w1_addr", 32'(wq[idx+1].a),  32'h21);
      chk("n5_w1_data", wq[idx+1].w,       32'h00000005);
      chk("n5_w1_be",   32'(wq[idx+1].be), 32'h1);
      chk("n5_w2_data", wq[idx+2].w,       32'h09080706);
      chk("n5_w9_addr", 32'(wq[idx+9].a),  32'h29);
      chk("n5_w9_data", wq[idx+9].w,       32'h00000019);
      chk("n5_w9_be",   32'(wq[idx+9].be), 32'h1);
    end

    // Reset in the middle of an N=4 transfer after 6 bytes
    start_xfer(1, 8'h00);
    feed(1, 8'h01, 6);
    rst_n = 1'b0;
    #1;
    chk_quiet_outputs(1, "midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idx = wq.size();
    start_xfer(1, 8'h40);
    feed(1, 8'h80, 16);
    wait_done(1);
    check_writes(1, 8'h40, 8'h80, 4, idx);
    if (wq.size() > idx) begin
      chk("postreset_addr", 32'(wq[idx].a), 32'h40);
      chk("postreset_data", wq[idx].w,      32'h83828180);
    end

    // elem_valid held high while idle: nothing consumed
    idx = wq.size();
    vld[0] = 1'b1;
    dat[0] = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(rdy[0]), 32'h0);
      chk("idle_busy",  32'(bsy[0]), 32'h0);
    end
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    chk("idle_no_write", 32'(wq.size() - idx), 32'd0);

    // start asserted in every busy cycle with a different base, stalled writes
    // so elem_valid is also held high during WRITE
    stall[0] = 2;
    spam[0]  = 1'b1;
    idx = wq.size();
    start_xfer(0, 8'h30);
    ba[0] = 8'h77;
    feed(0, 8'h11, 4);
    wait_done(0);
    spam[0]  = 1'b0;
    stall[0] = 0;
    check_writes(0, 8'h30, 8'h11, 2, idx);
    @(negedge clk);
    chk("spam_stays_idle", 32'(bsy[0]), 32'h0);
    @(posedge clk);
    #1;

    // Address wrap from 0xFF
    idx = wq.size();
    start_xfer(0, 8'hFF);
    feed(0, 8'h05, 4);
    wait_done(0);
    check_writes(0, 8'hFF, 8'h05, 2, idx);
    if (wq.size() >= idx + 2) begin
      chk("wrap_w0_addr", 32'(wq[idx].a),   32'hFF);
      chk("wrap_w1_addr", 32'(wq[idx+1].a), 32'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
